fb_writer_4p: RTL
=================

Name: fb_writer_4p

Overview:
Write-side companion for the 4-pixel-per-clock framebuffer BRAM. Accepts single-pixel draw requests (x, y, colour) from a drawing engine over valid/ready. Coalesces horizontally adjacent pixels into aligned 4-pixel groups and issues masked 4-pixel writes to the BRAM write port. Discards off-screen pixels, and optionally fills the whole buffer at 4 pixels/clock.

Parameters:
CORDW, 16, signed coordinate width (bits)
FB_WIDTH, 160, framebuffer width in pixels; must be a multiple of 4
FB_HEIGHT, 120, framebuffer height in pixels
FB_DATAW, 1, colour bits per pixel
FB_ADDRW, $clog2(FB_WIDTH*FB_HEIGHT), pixel address width

Ports:
clk_pix  in  1  pixel clock
rst_pix  in  1  reset, asynchronous, active-high
s_valid  in  1  pixel request valid
s_ready  out  1  writer can accept a request
s_x  in  CORDW  signed pixel x
s_y  in  CORDW  signed pixel y
s_colr  in  FB_DATAW  pixel colour
flush  in  1  pulse: write out the open group
clear  in  1  pulse: start a fill (FBW_CLEAR_EN only)
clear_colr  in  FB_DATAW  fill colour (FBW_CLEAR_EN only)
busy  out  1  high when a group is open, a flush is pending, a write is in flight, or a fill is running
dropped  out  1  one-cycle pulse for each discarded off-screen pixel
fb_we  out  1  BRAM write strobe
fb_addr  out  FB_ADDRW  pixel address of lane 0; always a multiple of 4
fb_mask  out  4  lane write enables; bit n writes pixel fb_addr+n
fb_data  out  4*FB_DATAW  lane n is bits [n*FB_DATAW +: FB_DATAW]

Behaviour:
- Reset values:
  - fb_we=0, fb_addr=0, fb_mask=0, fb_data=0.
  - dropped=0, busy=0, state IDLE, flush pending cleared.
  - s_ready=0 while rst_pix is high.
- A request is accepted on a clock edge where s_valid && s_ready.
- Clipping:
  - A pixel is in bounds when 0<=x<FB_WIDTH and 0<=y<FB_HEIGHT.
  - An out-of-bounds pixel pulses dropped on the next cycle and changes no other state.
- Addressing:
  - Pixel address a = y*FB_WIDTH + x, unsigned FB_ADDRW bits.
  - Group address = a with bits [1:0] cleared; lane = x[1:0].
- States: IDLE (no open group), OPEN (group buffer holds addr, mask, data), CLEAR.
- Accepted in-bounds pixel:
  - In IDLE: open a new group with only its lane set in the mask; go to OPEN.
  - In OPEN, same group: merge the pixel; a repeated lane overwrites the earlier colour.
  - In OPEN, different group: on the next edge, register the old group onto fb_*, pulse fb_we for one cycle, and open the new group with only its lane set.
- Flush:
  - In OPEN: the group is written on the next edge (fb_we for one cycle); go to IDLE.
  - In IDLE: no effect.
  - Flush in the same cycle as an accepted pixel: the pixel takes effect first; the flush is held pending and executes on the following edge.
  - A pending flush completes regardless of whether s_valid is presented in that cycle.
- Latency: a group appears on fb_* exactly one cycle after the triggering edge (mismatching pixel or flush execution).
- s_ready = !rst_pix && state!=CLEAR && !flush_pending; there is no other backpressure.
- Reset mid-operation: the open group, pending flush and any fill are abandoned; no partial write is issued.

Optional Feature:
FBW_CLEAR_EN.
- Defined:
  - A clear pulse while not in CLEAR discards any open group and pending flush, then enters CLEAR.
  - CLEAR issues FB_WIDTH*FB_HEIGHT/4 consecutive writes with fb_we=1, fb_mask=4'b1111, and every lane equal to clear_colr sampled at the pulse.
  - Addresses run 0, 4, 8, …; state returns to IDLE after the last write.
  - Clear during CLEAR is ignored.
- Undefined: the clear and clear_colr ports and the CLEAR state are absent.

Test Plan:
1. Defaults; pixels (4,0),(5,0),(7,0) colour 1, then flush -> one write: addr 4, mask 4'b1011, data 4'b1011; busy low afterwards.
2. (0,1) colour 1, then (4,1) colour 1, then flush -> write addr 160 mask 4'b0001 one cycle after the second pixel is accepted; then write addr 164 mask 4'b0001.
3. (-1,0), (160,5), (3,120) -> three dropped pulses, no fb_we, state stays IDLE.
4. (2,0) colour 1, then (2,0) colour 0, with flush asserted in the same cycle as the second pixel -> single write: addr 0, mask 4'b0100, data 4'b0000.
5. FBW_CLEAR_EN; clear with clear_colr=1 -> 4800 writes, addr 0..19196 step 4, mask 4'b1111, data 4'b1111; s_ready low for all 4800 cycles.
6. FBW_CLEAR_EN; rst_pix asserted after 100 fill writes -> fb_we=0 immediately and no further writes; s_ready=1 and busy=0 once reset is released.

Source files
------------

// File: rtl/fb_writer_4p.sv
// fb_writer_4p: write-side companion for a 4-pixel-per-clock framebuffer BRAM.
// Coalesces single-pixel draw requests into aligned 4-pixel groups and issues
// masked 4-pixel writes. Off-screen pixels are discarded with a dropped pulse.
// Optional feature macro: FBW_CLEAR_EN adds the clear/clear_colr ports and a
// whole-buffer fill at 4 pixels per clock.
module fb_writer_4p #(
  parameter int CORDW     = 16,
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int FB_DATAW  = 1,
  parameter int FB_ADDRW  = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [CORDW-1:0] s_x,
  input  logic signed [CORDW-1:0] s_y,
  input  logic [FB_DATAW-1:0]     s_colr,
  input  logic                    flush,
`ifdef FBW_CLEAR_EN
  input  logic                    clear,
  input  logic [FB_DATAW-1:0]     clear_colr,
`endif
  output logic                    busy,
  output logic                    dropped,
  output logic                    fb_we,
  output logic [FB_ADDRW-1:0]     fb_addr,
  output logic [3:0]              fb_mask,
  output logic [4*FB_DATAW-1:0]   fb_data
);

`ifdef FBW_CLEAR_EN
  typedef enum logic [1:0] {IDLE, OPEN, CLEAR} state_t;
  localparam logic [FB_ADDRW-1:0] LAST_ADDR = FB_ADDRW'(FB_WIDTH*FB_HEIGHT - 4);
`else
  typedef enum logic [0:0] {IDLE, OPEN} state_t;
`endif

  localparam logic signed [CORDW-1:0] X_LIM   = CORDW'(FB_WIDTH);
  localparam logic signed [CORDW-1:0] Y_LIM   = CORDW'(FB_HEIGHT);
  localparam logic [FB_ADDRW-1:0]     WIDTH_A = FB_ADDRW'(FB_WIDTH);

  state_t                state;
  logic                  flush_pending;
  logic [FB_ADDRW-1:0]   grp_addr;
  logic [3:0]            grp_mask;
  logic [4*FB_DATAW-1:0] grp_data;
`ifdef FBW_CLEAR_EN
  logic [FB_ADDRW-1:0]   clr_addr;
  logic [FB_DATAW-1:0]   clr_colr;
`endif

  logic                  in_bounds;
  logic                  accept;
  logic                  take;
  logic                  same_grp;
  logic                  in_clear;
  logic [1:0]            lane;
  logic [FB_ADDRW-1:0]   pix_addr;
  logic [FB_ADDRW-1:0]   pix_grp;
  logic [3:0]            new_mask;
  logic [4*FB_DATAW-1:0] new_data;

`ifdef FBW_CLEAR_EN
  assign in_clear = (state == CLEAR);
`else
  assign in_clear = 1'b0;
`endif

  // Handshake and status: no backpressure other than a pending flush or a fill.
  assign s_ready = !rst_pix && !in_clear && !flush_pending;
  assign busy    = (state != IDLE) || flush_pending || fb_we;
  assign accept  = s_valid && s_ready;

  // Sign bit checked explicitly so the bounds test never turns unsigned.
  assign in_bounds = !s_x[CORDW-1] && (s_x < X_LIM) && !s_y[CORDW-1] && (s_y < Y_LIM);
  assign take      = accept && in_bounds;
  assign pix_addr  = $unsigned(FB_ADDRW'(s_y)) * WIDTH_A + $unsigned(FB_ADDRW'(s_x));
  assign pix_grp   = {pix_addr[FB_ADDRW-1:2], 2'b00};
  assign lane      = s_x[1:0];
  assign same_grp  = (state == OPEN) && (grp_addr == pix_grp);

  // Group contents after the incoming pixel: merge into the open group or start fresh.
  always_comb begin
    // NOTE: every signal gets a default before the conditional update, so no latch is inferred.
    new_mask = same_grp ? grp_mask : 4'b0000;
    new_data = same_grp ? grp_data : '0;
    new_mask[lane] = 1'b1;
    new_data[lane*FB_DATAW +: FB_DATAW] = s_colr;
  end

  // Group buffer, flush handling, fill sequencing and the registered BRAM port.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
      grp_addr      <= '0;
      grp_mask      <= '0;
      grp_data      <= '0;
      fb_we         <= 1'b0;
      fb_addr       <= '0;
      fb_mask       <= '0;
      fb_data       <= '0;
      dropped       <= 1'b0;
`ifdef FBW_CLEAR_EN
      clr_addr      <= '0;
      clr_colr      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      fb_we   <= 1'b0;
      dropped <= accept && !in_bounds;
`ifdef FBW_CLEAR_EN
      if (state == CLEAR) begin
        fb_we    <= 1'b1;
        fb_addr  <= clr_addr;
        fb_mask  <= 4'b1111;
        fb_data  <= {4{clr_colr}};
        clr_addr <= clr_addr + FB_ADDRW'(4);
        if (clr_addr == LAST_ADDR) state <= IDLE;
      end else if (clear) begin
        state         <= CLEAR;
        flush_pending <= 1'b0;
        clr_addr      <= '0;
        clr_colr      <= clear_colr;
      end else
`endif
      if (flush_pending) begin
        if (state == OPEN) begin
          fb_we   <= 1'b1;
          fb_addr <= grp_addr;
          fb_mask <= grp_mask;
          fb_data <= grp_data;
        end
        state         <= IDLE;
        flush_pending <= 1'b0;
      end else if (take) begin
        if ((state == OPEN) && !same_grp) begin
          fb_we   <= 1'b1;
          fb_addr <= grp_addr;
          fb_mask <= grp_mask;
          fb_data <= grp_data;
        end
        grp_addr      <= pix_grp;
        grp_mask      <= new_mask;
        grp_data      <= new_data;
        state         <= OPEN;
        flush_pending <= flush;
      end else if (flush && (state == OPEN)) begin
        fb_we   <= 1'b1;
        fb_addr <= grp_addr;
        fb_mask <= grp_mask;
        fb_data <= grp_data;
        state   <= IDLE;
      end
    end
  end

endmodule
